// File: rtl/tqvp_multi_edge_counter_pkg.sv
// Shared constants for the multi-channel edge counter: register map,
// per-channel mode encodings, ID byte layout and the hex 7-segment table.
package tqvp_multi_edge_counter_pkg;

  localparam logic [3:0] ADDR_SNAP0_LO = 4'h0;
  localparam logic [3:0] ADDR_SNAP0_HI = 4'h1;
  localparam logic [3:0] ADDR_SNAP1_LO = 4'h2;
  localparam logic [3:0] ADDR_SNAP1_HI = 4'h3;
  localparam logic [3:0] ADDR_SNAP2_LO = 4'h4;
  localparam logic [3:0] ADDR_SNAP2_HI = 4'h5;
  localparam logic [3:0] ADDR_SNAP3_LO = 4'h6;
  localparam logic [3:0] ADDR_SNAP3_HI = 4'h7;
  localparam logic [3:0] ADDR_MODE     = 4'h8;
  localparam logic [3:0] ADDR_CMD      = 4'h9;
  localparam logic [3:0] ADDR_STATUS   = 4'hA;
  localparam logic [3:0] ADDR_CMP_LO   = 4'hB;
  localparam logic [3:0] ADDR_CMP_HI   = 4'hC;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'hD;
  localparam logic [3:0] ADDR_DISP_SEL = 4'hE;
  localparam logic [3:0] ADDR_ID       = 4'hF;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_RISE = 2'd1,
    MODE_FALL = 2'd2,
    MODE_BOTH = 2'd3
  } edge_mode_e;

  // ID byte: {tag, channel count - 1, counter width - 8}
  localparam logic [1:0] ID_TAG     = 2'b01;
  localparam int         ID_CH_W    = 2;
  localparam int         ID_WIDTH_W = 4;

  // Common-cathode hex digits, bit0 = segment A; entry 15 first
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/tqvp_edge_channel.sv
// One counting channel: input synchroniser, mode-qualified edge detect,
// counter with clear priority, and single-cycle overflow/match set pulses.
module tqvp_edge_channel
  import tqvp_multi_edge_counter_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pin,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic [CNT_W-1:0] cmp,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_set,
  output logic             match_set
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   sync_last;
  logic                   rise;
  logic                   fall;
  logic                   inc;
  edge_mode_e             mode_e;

  // Synchroniser chain and previous-sample flop; reset preloads the live pin
  // level so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{pin}};
      prev_q <= pin;
    end else begin
      sync_q[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev_q;
  assign fall      = ~sync_last & prev_q;
  assign mode_e    = edge_mode_e'(mode);

  // Keep only the edge polarities the channel mode asks for.
  always_comb begin
    inc = 1'b0;
    case (mode_e)
      MODE_RISE: inc = rise;
      MODE_FALL: inc = fall;
      MODE_BOTH: inc = rise | fall;
      default:   inc = 1'b0;
    endcase
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Counter; a clear overrides a coincident increment.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc) cnt_q <= cnt_inc;
  end

  // Flags only come from real increments, never from clear or reset.
  assign ovf_set   = inc & ~clr & (cnt_q == '1);
  assign match_set = inc & ~clr & (cnt_inc == cmp);
  assign cnt       = cnt_q;

endmodule

// File: rtl/tqvp_multi_edge_counter.sv
// Multi-channel edge counter peripheral: register file, snapshots, sticky
// status, registered interrupt and 7-segment display of one channel.
module tqvp_multi_edge_counter
  import tqvp_multi_edge_counter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       user_interrupt
);

  localparam logic [7:0] MODE_MASK = 8'((1 << (2 * NUM_CH)) - 1);
  localparam logic [3:0] CH_MASK   = 4'((1 << NUM_CH) - 1);
  localparam logic [7:0] ID_VAL    = {ID_TAG, ID_CH_W'(NUM_CH - 1), ID_WIDTH_W'(CNT_W - 8)};

  logic [CNT_W-1:0] cnt    [4];
  logic [CNT_W-1:0] snap_q [4];
  logic [3:0]       ovf_set;
  logic [3:0]       match_set;
  logic [3:0]       clr;
  logic [3:0]       cap;
  logic [7:0]       mode_q;
  logic [7:0]       status_q;
  logic [7:0]       status_nx;
  logic [7:0]       irq_en_q;
  logic [7:0]       irq_en_nx;
  logic [15:0]      cmp_q;
  logic [1:0]       disp_sel_q;
  logic [1:0]       disp_ch;
  logic [15:0]      snap_rd;
  logic             irq_q;
  logic             wr_cmd;
  logic             wr_status;
  logic             wr_irq_en;
  logic             unused_ui;

  assign wr_cmd    = data_write && (address == ADDR_CMD);
  assign wr_status = data_write && (address == ADDR_STATUS);
  assign wr_irq_en = data_write && (address == ADDR_IRQ_EN);
  assign clr       = wr_cmd ? (data_in[3:0] & CH_MASK) : 4'h0;
  assign cap       = wr_cmd ? (data_in[7:4] & CH_MASK) : 4'h0;
  assign unused_ui = ^ui_in;

  for (genvar c = 0; c < 4; c++) begin : g_ch
    if (c < NUM_CH) begin : g_on
      tqvp_edge_channel #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin       (ui_in[c]),
        .mode      (mode_q[2*c +: 2]),
        .clr       (clr[c]),
        .cmp       (cmp_q[CNT_W-1:0]),
        .cnt       (cnt[c]),
        .ovf_set   (ovf_set[c]),
        .match_set (match_set[c])
      );
    end else begin : g_off
      assign cnt[c]       = '0;
      assign ovf_set[c]   = 1'b0;
      assign match_set[c] = 1'b0;
    end
  end

  // Set pulses beat a coincident write-1-to-clear on the same bit.
  assign status_nx = (status_q & ~(wr_status ? data_in : 8'h00)) | {match_set, ovf_set};
  assign irq_en_nx = wr_irq_en ? data_in : irq_en_q;

  // Register file, snapshots and the interrupt flop (built from next-state
  // values so a clear or mask drop shows up right after the write edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q     <= '0;
      status_q   <= '0;
      irq_en_q   <= '0;
      cmp_q      <= '0;
      disp_sel_q <= '0;
      irq_q      <= 1'b0;
      for (int c = 0; c < 4; c++) snap_q[c] <= '0;
    end else begin
      if (data_write && address == ADDR_MODE)     mode_q        <= data_in & MODE_MASK;
      if (data_write && address == ADDR_CMP_LO)   cmp_q[7:0]    <= data_in;
      if (data_write && address == ADDR_CMP_HI)   cmp_q[15:8]   <= data_in;
      if (data_write && address == ADDR_DISP_SEL) disp_sel_q    <= data_in[1:0];
      irq_en_q <= irq_en_nx;
      status_q <= status_nx;
      irq_q    <= |(status_nx & irq_en_nx);
      for (int c = 0; c < 4; c++) begin
        if (cap[c]) snap_q[c] <= cnt[c];
      end
    end
  end

  assign snap_rd = 16'(snap_q[address[2:1]]);

  // Combinational read mux.
  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_MODE:     data_out = mode_q;
      ADDR_CMD:      data_out = 8'h00;
      ADDR_STATUS:   data_out = status_q;
      ADDR_CMP_LO:   data_out = cmp_q[7:0];
      ADDR_CMP_HI:   data_out = cmp_q[15:8];
      ADDR_IRQ_EN:   data_out = irq_en_q;
      ADDR_DISP_SEL: data_out = {6'b0, disp_sel_q};
      ADDR_ID:       data_out = ID_VAL;
      default:       data_out = address[0] ? snap_rd[15:8] : snap_rd[7:0];
    endcase
  end

  assign disp_ch        = (32'(disp_sel_q) < NUM_CH) ? disp_sel_q : 2'd0;
  assign uo_out         = {status_q[disp_ch], SEG_TABLE[cnt[disp_ch][3:0]]};
  assign user_interrupt = irq_q;

endmodule

// File: tb/tb_tqvp_multi_edge_counter.sv
// Bench for tqvp_multi_edge_counter: register vector table, directed corner
// sequences and randomised pin activity against a transition-counting model.
module tb_tqvp_multi_edge_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       user_interrupt;

  always #5 clk = ~clk;

  tqvp_multi_edge_counter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_write     (data_write),
    .data_in        (data_in),
    .data_out       (data_out),
    .user_interrupt (user_interrupt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counts qualifying pin transitions as the bench makes them.
  logic [15:0] m_cnt  [4];
  logic [15:0] m_snap [4];
  logic [7:0]  m_mode, m_status, m_irq_en, m_disp;
  logic [15:0] m_cmp;
  logic [7:0]  pins;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [13];

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  function automatic void m_inc(input int c);
    if (m_cnt[c] == 16'hFFFF) begin
      m_cnt[c] = 16'h0000;
      m_status[c] = 1'b1;
    end else begin
      m_cnt[c] = m_cnt[c] + 16'd1;
    end
    if (m_cnt[c] == m_cmp) m_status[4+c] = 1'b1;
  endfunction

  function automatic logic [7:0] m_uo();
    logic [1:0] s;
    s = m_disp[1:0];
    return {m_status[s], seg_of(m_cnt[s][3:0])};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [7:0] d);
    settle();
    address = a; data_in = d; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
    case (a)
      4'h8: m_mode = d;
      4'h9: for (int c = 0; c < 4; c++) begin
              if (d[4+c]) m_snap[c] = m_cnt[c];
              if (d[c])   m_cnt[c]  = 16'h0000;
            end
      4'hA: m_status = m_status & ~d;
      4'hB: m_cmp[7:0] = d;
      4'hC: m_cmp[15:8] = d;
      4'hD: m_irq_en = d;
      4'hE: m_disp = {6'b0, d[1:0]};
      default: ;
    endcase
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] d);
    settle();
    address = a;
    #1 d = data_out;
  endtask

  task automatic drive_pins(input logic [7:0] nw);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      case (m_mode[2*c +: 2])
        2'd1: if (!pins[c] && nw[c]) m_inc(c);
        2'd2: if (pins[c] && !nw[c]) m_inc(c);
        2'd3: if (pins[c] != nw[c])  m_inc(c);
        default: ;
      endcase
    end
    pins = nw;
    ui_in = nw;
  endtask

  // Toggle pins, then strobe CMD exactly in the cycle the edge reaches the counter.
  task automatic coincide(input logic [7:0] cmdv, input logic [7:0] flip);
    settle();
    pins = pins ^ flip;
    ui_in = pins;
    @(negedge clk);
    @(negedge clk);
    address = 4'h9; data_in = cmdv; data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic check_snaps(input string tag);
    logic [7:0] lo, hi;
    write_reg(4'h9, 8'hF0);
    for (int c = 0; c < 4; c++) begin
      read_reg(4'(2*c), lo);
      read_reg(4'(2*c+1), hi);
      check($sformatf("%s_snap%0d", tag, c), {hi, lo}, m_snap[c]);
    end
  endtask

  task automatic check_status(input string tag);
    logic [7:0] rd;
    read_reg(4'hA, rd);
    check({tag, "_status"}, rd, m_status);
  endtask

  task automatic check_outs(input string tag);
    settle();
    #1;
    check({tag, "_uo"}, uo_out, m_uo());
    check({tag, "_irq"}, user_interrupt, |(m_status & m_irq_en));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    vecs[0]  = '{4'h8, 8'hE4, 8'hE4};
    vecs[1]  = '{4'hB, 8'h34, 8'h34};
    vecs[2]  = '{4'hC, 8'h12, 8'h12};
    vecs[3]  = '{4'hD, 8'hA5, 8'hA5};
    vecs[4]  = '{4'hE, 8'hFE, 8'h02};
    vecs[5]  = '{4'h9, 8'h00, 8'h00};
    vecs[6]  = '{4'hF, 8'h00, 8'h78};
    vecs[7]  = '{4'h3, 8'hFF, 8'h00};
    vecs[8]  = '{4'hA, 8'hFF, 8'h00};
    vecs[9]  = '{4'hD, 8'h00, 8'h00};
    vecs[10] = '{4'hE, 8'h00, 8'h00};
    vecs[11] = '{4'hC, 8'h80, 8'h80};
    vecs[12] = '{4'hB, 8'h00, 8'h00};

    for (int c = 0; c < 4; c++) begin m_cnt[c] = 0; m_snap[c] = 0; end
    m_mode = 0; m_status = 0; m_irq_en = 0; m_disp = 0; m_cmp = 0;
    rst_n = 1'b0; ui_in = 8'h01; pins = 8'h01;
    address = 4'h0; data_in = 8'h00; data_write = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Reset state and no phantom edge from a high pin
    #1;
    check("reset_uo", uo_out, 8'h3F);
    check("reset_irq", user_interrupt, 1'b0);
    write_reg(4'h9, 8'h10);
    read_reg(4'h0, rd); check("reset_snap0_lo", rd, 8'h00);
    read_reg(4'h1, rd); check("reset_snap0_hi", rd, 8'h00);
    read_reg(4'hF, rd); check("id", rd, 8'h78);

    // Register access table
    foreach (vecs[i]) begin
      write_reg(vecs[i].addr, vecs[i].wdata);
      read_reg(vecs[i].addr, rd);
      check($sformatf("vec%0d_addr%h", i, vecs[i].addr), rd, vecs[i].exp);
    end

    // Per-channel modes: off, rise, fall, both with 5 full pulses
    drive_pins(8'h00);
    write_reg(4'h9, 8'h0F);
    repeat (5) begin drive_pins(8'h0F); drive_pins(8'h00); end
    check_snaps("modes");
    check_status("modes");

    // Randomised activity
    for (int r = 0; r < 6; r++) begin
      write_reg(4'h8, 8'($urandom));
      write_reg(4'hE, 8'($urandom));
      repeat (40) drive_pins(8'($urandom));
      check_snaps($sformatf("rnd%0d", r));
      check_status($sformatf("rnd%0d", r));
      check_outs($sformatf("rnd%0d", r));
    end

    // Display of channel 1 at 0x1A
    write_reg(4'hA, 8'hFF);
    write_reg(4'h9, 8'h02);
    write_reg(4'h8, 8'h04);
    write_reg(4'hE, 8'h01);
    if (pins[1]) drive_pins(pins & ~8'h02);
    repeat (26) begin drive_pins(pins | 8'h02); drive_pins(pins & ~8'h02); end
    check_outs("disp");
    #1 check("disp_1a", uo_out, 8'h77);

    // Overflow of channel 1 and interrupt clear
    write_reg(4'h9, 8'h02);
    write_reg(4'h8, 8'h0C);
    repeat (65535) drive_pins(pins ^ 8'h02);
    write_reg(4'hA, 8'hFF);
    write_reg(4'h8, 8'h04);
    check_snaps("preload");
    write_reg(4'hD, 8'h02);
    check_outs("preload");
    if (pins[1]) drive_pins(pins & ~8'h02);
    drive_pins(pins | 8'h02);
    check_outs("ovf");
    check("ovf_uo_dp", uo_out, 8'hBF);
    check("ovf_irq_on", user_interrupt, 1'b1);
    check_status("ovf");
    write_reg(4'hA, 8'h02);
    check("irq_after_w1c", user_interrupt, 1'b0);

    // Compare match on channel 2, then clears never match
    write_reg(4'hD, 8'h00);
    write_reg(4'hC, 8'h00);
    write_reg(4'hB, 8'h03);
    write_reg(4'h8, 8'h30);
    write_reg(4'h9, 8'h04);
    repeat (3) drive_pins(pins ^ 8'h04);
    check_status("match");
    write_reg(4'hA, 8'h40);
    write_reg(4'h9, 8'h04);
    check_status("match_clr");
    write_reg(4'hB, 8'h00);
    write_reg(4'h9, 8'h04);
    check_status("clr_cmp0");
    repeat (2) drive_pins(pins ^ 8'h04);
    coincide(8'h04, 8'h04);
    m_cnt[2] = 16'h0000;
    check_snaps("clr_edge");
    check_status("clr_edge");

    // Capture, and capture+clear, in the same cycle as an edge on channel 0
    write_reg(4'h8, 8'h01);
    if (pins[0]) drive_pins(pins & ~8'h01);
    write_reg(4'h9, 8'h01);
    repeat (3) begin drive_pins(pins | 8'h01); drive_pins(pins & ~8'h01); end
    coincide(8'h10, 8'h01);
    m_snap[0] = m_cnt[0];
    m_inc(0);
    read_reg(4'h0, rd); check("cap_edge_lo", rd, m_snap[0][7:0]);
    read_reg(4'h1, rd); check("cap_edge_hi", rd, m_snap[0][15:8]);
    check_snaps("cap_edge");
    drive_pins(pins & ~8'h01);
    coincide(8'h11, 8'h01);
    m_snap[0] = m_cnt[0];
    m_cnt[0] = 16'h0000;
    read_reg(4'h0, rd); check("capclr_edge_lo", rd, m_snap[0][7:0]);
    read_reg(4'h1, rd); check("capclr_edge_hi", rd, m_snap[0][15:8]);
    check_snaps("capclr_edge");
    check_status("capclr_edge");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
